// File: rtl/processor_pkg.sv
// Shared encodings for the single-cycle core: opcodes, ALU operations,
// status codes written to r30 on arithmetic exceptions, and fixed registers.
package processor_pkg;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_J     = 5'b00001;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SETX  = 5'b10101;
  localparam logic [4:0] OP_BEX   = 5'b10110;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;
  localparam logic [4:0] ALU_AND = 5'b00010;
  localparam logic [4:0] ALU_OR  = 5'b00011;
  localparam logic [4:0] ALU_SLL = 5'b00100;
  localparam logic [4:0] ALU_SRA = 5'b00101;
  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;

  typedef enum logic [2:0] {
    EXC_NONE     = 3'd0,
    EXC_ADD_OVF  = 3'd1,
    EXC_ADDI_OVF = 3'd2,
    EXC_SUB_OVF  = 3'd3,
    EXC_MUL_OVF  = 3'd4,
    EXC_DIV_ZERO = 3'd5
  } exc_code_t;

  localparam logic [4:0] R_ZERO   = 5'd0;
  localparam logic [4:0] R_STATUS = 5'd30;
  localparam logic [4:0] R_RA     = 5'd31;

  // 17-bit immediate, sign-extended
  function automatic logic [31:0] sign_ext_imm(input logic [31:0] instr);
    return {{15{instr[16]}}, instr[16:0]};
  endfunction

  // 27-bit jump target, zero-extended
  function automatic logic [31:0] zero_ext_target(input logic [31:0] instr);
    return {5'd0, instr[26:0]};
  endfunction

  // Only aluop values 0..7 are defined; everything else is a nop
  function automatic logic is_known_aluop(input logic [4:0] op);
    return (op[4:3] == 2'b00);
  endfunction

  function automatic logic [31:0] status_word(input exc_code_t code);
    return {29'd0, code};
  endfunction

endpackage

// File: rtl/processor_alu.sv
// Combinational ALU: arithmetic/logic/shift/mul/div plus compare flags used
// by the branches. overflow is only meaningful for add, sub and mul.
module processor_alu
  import processor_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  aluop,
  input  logic [4:0]  shamt,
  output logic [31:0] result,
  output logic        is_not_equal,
  output logic        is_less_than,
  output logic        overflow
);

  logic [31:0]        sum;
  logic [31:0]        diff;
  logic signed [63:0] a_ext;
  logic signed [63:0] b_ext;
  logic [63:0]        product;
  logic [31:0]        quotient;

  assign sum     = a + b;
  assign diff    = a - b;
  assign a_ext   = {{32{a[31]}}, a};
  assign b_ext   = {{32{b[31]}}, b};
  assign product = a_ext * b_ext;

  assign is_not_equal = (a != b);
  assign is_less_than = ($signed(a) < $signed(b));

  // Signed truncating divide; zero divisor and INT_MIN/-1 are steered away from the divider
  always_comb begin
    quotient = 32'd0;
    if (b == 32'd0) begin
      quotient = 32'd0;
    end else if (b == 32'hFFFF_FFFF) begin
      quotient = 32'd0 - a;
    end else begin
      quotient = $signed(a) / $signed(b);
    end
  end

  // Operation select and signed-overflow detection
  always_comb begin
    result   = 32'd0;
    overflow = 1'b0;
    case (aluop)
      ALU_ADD: begin
        result   = sum;
        overflow = (a[31] == b[31]) && (sum[31] != a[31]);
      end
      ALU_SUB: begin
        result   = diff;
        overflow = (a[31] != b[31]) && (diff[31] != a[31]);
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLL: result = a << shamt;
      ALU_SRA: result = $signed(a) >>> shamt;
      ALU_MUL: begin
        result   = product[31:0];
        overflow = (product[63:32] != {32{product[31]}});
      end
      ALU_DIV: result = quotient;
      default: result = 32'd0;
    endcase
  end

endmodule

// File: rtl/processor.sv
// Single-cycle 32-bit core. Only the PC is stored here; instruction memory,
// data memory/MMIO and the register file live outside and are driven
// combinationally from the current instruction word and register data.
module processor
  import processor_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'd0
)
(
  input  logic        clock,
  input  logic        reset,
  output logic [11:0] address_imem,
  input  logic [31:0] q_imem,
  output logic [16:0] address_dmem,
  output logic [31:0] data,
  output logic        wren,
  input  logic [31:0] q_dmem,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [4:0]  ctrl_readRegA,
  output logic [4:0]  ctrl_readRegB,
  output logic [31:0] data_writeReg,
  input  logic [31:0] data_readRegA,
  input  logic [31:0] data_readRegB
);

  logic [31:0] pc;
  logic [31:0] next_pc;
  logic [31:0] pc_plus1;
  logic [31:0] branch_target;
  logic [31:0] imm_ext;
  logic [31:0] target;

  logic [4:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  shamt;
  logic [4:0]  aluop;

  logic [31:0] alu_b;
  logic [4:0]  alu_op;
  logic [31:0] alu_result;
  logic        alu_not_equal;
  logic        alu_less_than;
  logic        alu_overflow;

  exc_code_t   r_exc;
  logic        wr_en;
  logic [4:0]  wr_reg;
  logic [31:0] wr_data;

  assign opcode = q_imem[31:27];
  assign rd     = q_imem[26:22];
  assign rs     = q_imem[21:17];
  assign rt     = q_imem[16:12];
  assign shamt  = q_imem[11:7];
  assign aluop  = q_imem[6:2];

  assign imm_ext       = sign_ext_imm(q_imem);
  assign target        = zero_ext_target(q_imem);
  assign pc_plus1      = pc + 32'd1;
  assign branch_target = pc_plus1 + imm_ext;

  // PC register, asynchronously forced to RESET_PC
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc <= RESET_PC;
    end else begin
      pc <= next_pc;
    end
  end

  assign address_imem = pc[11:0];

  // Register read selects and ALU operand/operation steering
  always_comb begin
    ctrl_readRegA = R_ZERO;
    ctrl_readRegB = R_ZERO;
    alu_b         = data_readRegB;
    alu_op        = ALU_ADD;
    case (opcode)
      OP_RTYPE: begin
        ctrl_readRegA = rs;
        ctrl_readRegB = rt;
        alu_op        = aluop;
      end
      OP_ADDI, OP_LW: begin
        ctrl_readRegA = rs;
        alu_b         = imm_ext;
      end
      OP_SW: begin
        ctrl_readRegA = rs;
        ctrl_readRegB = rd;
        alu_b         = imm_ext;
      end
      OP_BNE, OP_BLT: begin
        ctrl_readRegA = rd;
        ctrl_readRegB = rs;
      end
      OP_JR:   ctrl_readRegB = rd;
      OP_BEX:  ctrl_readRegA = R_STATUS;
      default: ;
    endcase
  end

  processor_alu u_alu (
    .a            (data_readRegA),
    .b            (alu_b),
    .aluop        (alu_op),
    .shamt        (shamt),
    .result       (alu_result),
    .is_not_equal (alu_not_equal),
    .is_less_than (alu_less_than),
    .overflow     (alu_overflow)
  );

  // R-type exception classification; divide-by-zero is detected on the raw divisor
  always_comb begin
    r_exc = EXC_NONE;
    case (aluop)
      ALU_ADD: if (alu_overflow) r_exc = EXC_ADD_OVF;
      ALU_SUB: if (alu_overflow) r_exc = EXC_SUB_OVF;
      ALU_MUL: if (alu_overflow) r_exc = EXC_MUL_OVF;
      ALU_DIV: if (data_readRegB == 32'd0) r_exc = EXC_DIV_ZERO;
      default: r_exc = EXC_NONE;
    endcase
  end

  // Writeback, store enable and next-PC selection
  always_comb begin
    wr_en   = 1'b0;
    wr_reg  = rd;
    wr_data = alu_result;
    wren    = 1'b0;
    next_pc = pc_plus1;
    case (opcode)
      OP_RTYPE: begin
        if (is_known_aluop(aluop)) begin
          wr_en = 1'b1;
          if (r_exc != EXC_NONE) begin
            wr_reg  = R_STATUS;
            wr_data = status_word(r_exc);
          end
        end
      end
      OP_ADDI: begin
        wr_en = 1'b1;
        if (alu_overflow) begin
          wr_reg  = R_STATUS;
          wr_data = status_word(EXC_ADDI_OVF);
        end
      end
      OP_LW: begin
        wr_en   = 1'b1;
        wr_data = q_dmem;
      end
      OP_SW:  wren = 1'b1;
      OP_BNE: if (alu_not_equal) next_pc = branch_target;
      OP_BLT: if (alu_less_than) next_pc = branch_target;
      OP_J:   next_pc = target;
      OP_JAL: begin
        wr_en   = 1'b1;
        wr_reg  = R_RA;
        wr_data = pc_plus1;
        next_pc = target;
      end
      OP_JR:  next_pc = data_readRegB;
      OP_BEX: if (data_readRegA != 32'd0) next_pc = target;
      OP_SETX: begin
        wr_en   = 1'b1;
        wr_reg  = R_STATUS;
        wr_data = target;
      end
      default: ;
    endcase
  end

  // r0 is hardwired; never request a write to it
  assign ctrl_writeEnable = wr_en && (wr_reg != R_ZERO);
  assign ctrl_writeReg    = wr_reg;
  assign data_writeReg    = wr_data;
  assign address_dmem     = alu_result[16:0];
  assign data             = data_readRegB;

endmodule

// File: tb/tb_processor.sv
// Bench for the single-cycle core. The bench plays the external register
// file; each instruction's expected outputs are queued by the driver and
// compared by an independent monitor on the falling edge.
module tb_processor;

  logic        clock;
  logic        reset;
  logic [11:0] address_imem;
  logic [31:0] q_imem;
  logic [16:0] address_dmem;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q_dmem;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [4:0]  ctrl_readRegA;
  logic [4:0]  ctrl_readRegB;
  logic [31:0] data_writeReg;
  logic [31:0] data_readRegA;
  logic [31:0] data_readRegB;

  logic [31:0] regs [32];

  typedef struct {
    int          id;
    logic [11:0] pc;
    logic        we;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic        wren;
    logic [16:0] adm;
    logic [31:0] sdata;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   n_tests = 0;
  int   n_fail  = 0;

  processor #(.RESET_PC(32'd0)) dut (
    .clock            (clock),
    .reset            (reset),
    .address_imem     (address_imem),
    .q_imem           (q_imem),
    .address_dmem     (address_dmem),
    .data             (data),
    .wren             (wren),
    .q_dmem           (q_dmem),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .ctrl_readRegA    (ctrl_readRegA),
    .ctrl_readRegB    (ctrl_readRegB),
    .data_writeReg    (data_writeReg),
    .data_readRegA    (data_readRegA),
    .data_readRegB    (data_readRegB)
  );

  assign data_readRegA = regs[ctrl_readRegA];
  assign data_readRegB = regs[ctrl_readRegB];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] enc_r(int rd, int rs, int rt, int sh, int aop);
    return {5'd0, 5'(rd), 5'(rs), 5'(rt), 5'(sh), 5'(aop), 2'b00};
  endfunction

  function automatic logic [31:0] enc_i(int op, int rd, int rs, int imm);
    return {5'(op), 5'(rd), 5'(rs), 17'(imm)};
  endfunction

  function automatic logic [31:0] enc_j(int op, int t);
    return {5'(op), 27'(t)};
  endfunction

  function automatic exp_t x_wr(int id, int pc, int r, logic [31:0] d);
    exp_t e;
    e = '{id: id, pc: 12'(pc), we: 1'b1, wreg: 5'(r), wdata: d,
          wren: 1'b0, adm: 17'd0, sdata: 32'd0};
    return e;
  endfunction

  function automatic exp_t x_none(int id, int pc);
    exp_t e;
    e = '{id: id, pc: 12'(pc), we: 1'b0, wreg: 5'd0, wdata: 32'd0,
          wren: 1'b0, adm: 17'd0, sdata: 32'd0};
    return e;
  endfunction

  function automatic exp_t x_st(int id, int pc, int a, logic [31:0] d);
    exp_t e;
    e = '{id: id, pc: 12'(pc), we: 1'b0, wreg: 5'd0, wdata: 32'd0,
          wren: 1'b1, adm: 17'(a), sdata: d};
    return e;
  endfunction

  task automatic check(input int id, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL v%0d %s: got %h expected %h", id, nm, act, exp);
    end
  endtask

  // Monitor: compare the oldest queued expectation against the DUT outputs
  always @(negedge clock) begin
    if (exp_q.size() != 0) begin
      cur = exp_q.pop_front();
      check(cur.id, "pc", {20'd0, address_imem}, {20'd0, cur.pc});
      check(cur.id, "writeEnable", {31'd0, ctrl_writeEnable}, {31'd0, cur.we});
      if (cur.we) begin
        check(cur.id, "writeReg", {27'd0, ctrl_writeReg}, {27'd0, cur.wreg});
        check(cur.id, "writeData", data_writeReg, cur.wdata);
      end
      check(cur.id, "wren", {31'd0, wren}, {31'd0, cur.wren});
      if (cur.wren) begin
        check(cur.id, "address_dmem", {15'd0, address_dmem}, {15'd0, cur.adm});
        check(cur.id, "store_data", data, cur.sdata);
      end
    end
  end

  // Present one instruction, then commit the register-file write after the check
  task automatic apply(input logic [31:0] ins, input logic [31:0] qd, input exp_t e);
    q_imem = ins;
    q_dmem = qd;
    exp_q.push_back(e);
    @(negedge clock);
    #1;
    if (ctrl_writeEnable && ctrl_writeReg != 5'd0) regs[ctrl_writeReg] = data_writeReg;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic step(input logic [31:0] ins, input logic [31:0] qd, input exp_t e);
    apply(ins, qd, e);
    next_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    q_imem = 32'd0;
    q_dmem = 32'd0;
    reset  = 1'b1;
    next_cycle();
    check(0, "reset_pc", {20'd0, address_imem}, 32'd0);
    reset = 1'b0;

    // arithmetic, overflow and shifts
    step(enc_i(5, 1, 0, 5), 0, x_wr(1, 0, 1, 32'd5));
    step(enc_r(2, 1, 1, 0, 0), 0, x_wr(2, 1, 2, 32'd10));
    regs[1] = 32'h7FFF_FFFF;
    step(enc_r(2, 1, 1, 0, 0), 0, x_wr(3, 2, 30, 32'd1));
    regs[7] = 32'hFFFF_FFFF;
    step(enc_r(6, 1, 7, 0, 1), 0, x_wr(4, 3, 30, 32'd3));
    step(enc_r(6, 7, 0, 4, 4), 0, x_wr(5, 4, 6, 32'hFFFF_FFF0));
    step(enc_r(8, 6, 0, 4, 5), 0, x_wr(6, 5, 8, 32'hFFFF_FFFF));
    regs[10] = 32'h0001_0000;
    regs[11] = 32'h0001_0000;
    step(enc_r(9, 10, 11, 0, 6), 0, x_wr(7, 6, 30, 32'd4));
    apply(enc_r(5, 1, 0, 0, 7), 0, x_wr(8, 7, 30, 32'd5));

    // reset mid-cycle while PC = 7: takes effect without a clock edge
    #1 reset = 1'b1;
    #1 check(100, "reset_async_pc", {20'd0, address_imem}, 32'd0);
    next_cycle();
    check(101, "reset_held_pc", {20'd0, address_imem}, 32'd0);
    reset = 1'b0;

    regs[13] = 32'hFFFF_FFF9;
    regs[14] = 32'd2;
    regs[17] = 32'h0000_FF0F;
    step(enc_r(12, 13, 14, 0, 7), 0, x_wr(9, 0, 12, 32'hFFFF_FFFD));
    step(enc_r(15, 13, 14, 0, 3), 0, x_wr(10, 1, 15, 32'hFFFF_FFFB));
    step(enc_r(16, 13, 17, 0, 2), 0, x_wr(11, 2, 16, 32'h0000_FF09));

    // memory access
    regs[1] = 32'd4096;
    regs[3] = 32'd9;
    step(enc_i(7, 3, 1, 4), 0, x_st(12, 3, 4100, 32'd9));
    step(enc_i(8, 4, 0, 4096), 32'd3, x_wr(13, 4, 4, 32'd3));

    // branches and jumps; next PC is seen as the following vector's pc
    step(enc_j(1, 10), 0, x_none(14, 5));
    step(enc_i(2, 1, 2, -2), 0, x_none(15, 10));
    step(enc_j(1, 10), 0, x_none(16, 9));
    regs[2] = 32'd4096;
    step(enc_i(2, 1, 2, -2), 0, x_none(17, 10));
    regs[1] = 32'hFFFF_FFFF;
    regs[2] = 32'd0;
    step(enc_i(6, 1, 2, 5), 0, x_none(18, 11));
    step(enc_i(6, 2, 1, 5), 0, x_none(19, 17));
    step(enc_j(1, 5), 0, x_none(20, 18));
    step(enc_j(3, 20), 0, x_wr(21, 5, 31, 32'd6));
    step(enc_i(4, 31, 0, 0), 0, x_none(22, 20));
    step(enc_j(21, 3), 0, x_wr(23, 6, 30, 32'd3));
    step(enc_j(22, 40), 0, x_none(24, 7));

    // r0 suppression, addi overflow, bex not taken, nops
    step(enc_i(5, 0, 0, 1), 0, x_none(25, 40));
    regs[21] = 32'h8000_0000;
    step(enc_i(5, 20, 21, -1), 0, x_wr(26, 41, 30, 32'd2));
    regs[30] = 32'd0;
    step(enc_j(22, 100), 0, x_none(27, 42));
    step(enc_j(31, 0), 0, x_none(28, 43));
    step(enc_r(5, 1, 2, 0, 8), 0, x_none(29, 44));
    step(enc_r(9, 13, 14, 0, 6), 0, x_wr(30, 45, 9, 32'hFFFF_FFF2));
    step(enc_i(5, 1, 0, 1), 0, x_wr(31, 46, 1, 32'd1));

    repeat (2) next_cycle();
    check(200, "queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
